// File: rtl/decryption.sv
// rtl/decryption.sv - UART-paced AES-128 block decrypter with edge-triggered requests.
// Optional one-deep request queue when DECRYPTION_QUEUE_EN is defined.
module decryption #(
  parameter int unsigned  CLOCK_PER_BIT = 10417,
  parameter logic [127:0] KEY           = 128'h5468617473206d79204b756e67204675
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] encoded_data,
  input  logic         encoded_state,
  output logic [127:0] decoded_data,
  output logic         decoded_state,
  output logic         busy,
  output logic         overrun
);
  localparam logic [24:0] DECODE_CYCLES = 25'(CLOCK_PER_BIT * 159);
  localparam logic [24:0] HOLD_CYCLES   = 25'(CLOCK_PER_BIT << 3);

  typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

  state_t       state_q, state_d;
  logic [24:0]  cnt_q, cnt_d;
  logic [127:0] cipher_q, cipher_d;
  logic [127:0] data_d;
  logic         dstate_d, busy_d, ovr_d;
  logic         enc_prev_q, primed_q;
  logic         req;
  logic         hold_exit;
  logic [127:0] plain;

`ifdef DECRYPTION_QUEUE_EN
  logic         pend_valid_q, pend_valid_d;
  logic [127:0] pend_data_q, pend_data_d;
`endif

  decrypter u_decrypter (
    .ciphertext (cipher_q),
    .key        (KEY),
    .plaintext  (plain)
  );

  // primed_q masks the first post-reset sample so a level already high at release is ignored
  assign req       = primed_q & encoded_state & ~enc_prev_q;
  assign hold_exit = (state_q == HOLD) && (cnt_q == HOLD_CYCLES - 25'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cipher_d = cipher_q;
    data_d   = decoded_data;
    dstate_d = decoded_state;
    busy_d   = busy;
    ovr_d    = overrun;
`ifdef DECRYPTION_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cipher_d = encoded_data;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (cnt_q == DECODE_CYCLES - 25'd1) begin
          data_d   = plain;
          dstate_d = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      HOLD: begin
        if (hold_exit) begin
          dstate_d = 1'b0;
          cnt_d    = '0;
`ifdef DECRYPTION_QUEUE_EN
          if (pend_valid_q) begin
            cipher_d     = pend_data_q;
            pend_valid_d = 1'b0;
            state_d      = DECODE;
          end else if (req) begin
            // an empty queue slot taken on the exit cycle is started straight away
            cipher_d = encoded_data;
            state_d  = DECODE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (req && (state_q != IDLE)) begin
`ifdef DECRYPTION_QUEUE_EN
      if (pend_valid_q) begin
        ovr_d = 1'b1;
      end else if (!hold_exit) begin
        pend_valid_d = 1'b1;
        pend_data_d  = encoded_data;
      end
`else
      ovr_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cipher_q      <= '0;
      decoded_data  <= '0;
      decoded_state <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      enc_prev_q    <= 1'b0;
      primed_q      <= 1'b0;
`ifdef DECRYPTION_QUEUE_EN
      pend_valid_q  <= 1'b0;
      pend_data_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cipher_q      <= cipher_d;
      decoded_data  <= data_d;
      decoded_state <= dstate_d;
      busy          <= busy_d;
      overrun       <= ovr_d;
      enc_prev_q    <= encoded_state;
      primed_q      <= 1'b1;
`ifdef DECRYPTION_QUEUE_EN
      pend_valid_q  <= pend_valid_d;
      pend_data_q   <= pend_data_d;
`endif
    end
  end
endmodule

// Combinational AES-128 inverse cipher; S-boxes derived from GF(2^8) inversion plus affine map.
module decrypter (
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = ginv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] pt;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      // inverse ShiftRows and SubBytes fused, then AddRoundKey
      for (int b = 0; b < 16; b++)
        u[b] = inv_sbox(s[4*((b/4 - b%4 + 4) % 4) + b%4]) ^ w[4*r + b/4][31-8*(b%4) -: 8];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c];
        a1 = u[4*c+1];
        a2 = u[4*c+2];
        a3 = u[4*c+3];
        if (r > 0) begin
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end else begin
          s[4*c]   = a0;
          s[4*c+1] = a1;
          s[4*c+2] = a2;
          s[4*c+3] = a3;
        end
      end
    end
    for (int b = 0; b < 16; b++) pt[127-8*b -: 8] = s[b];
    return pt;
  endfunction

  assign plaintext = inv_cipher(ciphertext, key);
endmodule

// File: doc/decryption.md
DECRYPTION -- requirements
Module: decryption

Interface
REQ-001 SHALL have parameter CLOCK_PER_BIT, default 10417, meaning the UART bit period in clk cycles; all timing below derives from it.
REQ-002 SHALL have parameter KEY, default 128'h5468617473206d79204b756e67204675, meaning the AES-128 cipher key.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port encoded_data, input, 128, ciphertext block.
REQ-006 SHALL have port encoded_state, input, 1, ciphertext-valid level; it may stay high for many cycles.
REQ-007 SHALL have port decoded_data, output, 128, registered plaintext.
REQ-008 SHALL have port decoded_state, output, 1, plaintext-valid level.
REQ-009 SHALL have port busy, output, 1, high while a block is in DECODE or HOLD.
REQ-010 SHALL have port overrun, output, 1, sticky flag set when a request is dropped.

Function
REQ-011 SHALL instantiate the team combinational inverse-cipher core decrypter(ciphertext, key, plaintext) on the internal cipher register and KEY.
REQ-012 SHALL register encoded_state each cycle; a request is a rising edge: current sample 1 and previous sample 0. A level held high SHALL produce exactly one request.
REQ-013 SHALL define DECODE_CYCLES = CLOCK_PER_BIT*159 and HOLD_CYCLES = CLOCK_PER_BIT<<3, using a 25-bit counter with no wrap for the default parameter.
REQ-014 SHALL implement a state machine with the states IDLE, DECODE and HOLD.
REQ-015 IDLE: on a request, capture encoded_data into the cipher register, clear the counter, set busy, and go to DECODE.
REQ-016 DECODE: increment the counter. When it reaches DECODE_CYCLES-1, load the decrypter output into decoded_data, set decoded_state, clear the counter, and go to HOLD. decoded_state therefore rises exactly DECODE_CYCLES cycles after the capture edge.
REQ-017 HOLD: hold decoded_state high for exactly HOLD_CYCLES cycles, then drop it. Next state is DECODE if a request is pending (REQ-019), otherwise IDLE with busy cleared.
REQ-018 decoded_data SHALL hold its value until the next completed decode; it is never cleared outside reset.
REQ-019 A request arriving in the same cycle decoded_state drops SHALL be treated as arriving while busy.
REQ-020 overrun SHALL stay set until reset. Changes to encoded_data after the capture edge SHALL NOT affect the block in progress.

Reset
REQ-021 When rst_n=0 at posedge clk, the block SHALL enter IDLE and clear the following: counter=0, decoded_data=0, decoded_state=0, busy=0, overrun=0, pending flag=0, edge-detect register=0.
REQ-022 Reset mid-DECODE or mid-HOLD SHALL abandon the block with no decoded_state pulse. A level-high encoded_state at reset release SHALL NOT trigger a request.

Configuration
REQ-023 Macro DECRYPTION_QUEUE_EN defined: a request while busy SHALL capture encoded_data into a one-deep pending register. The pending block SHALL start DECODE on leaving HOLD. A further request while pending is full SHALL be dropped and set overrun.
REQ-024 Macro DECRYPTION_QUEUE_EN undefined: every request while busy SHALL be dropped and set overrun; no pending register is built.

Verification (CLOCK_PER_BIT=2: DECODE_CYCLES=318, HOLD_CYCLES=16)
REQ-025 Known-answer test.
- Stimulus: encoded_data=29c3505f571420f6402299b31a02d73a, encoded_state high for 16 cycles.
- Response: decoded_data=54776f204f6e65204e696e652054776f; decoded_state rises 318 cycles after the edge and stays high for 16 cycles; busy drops afterwards.
REQ-026 Level hold: encoded_state held high for 1000 cycles -> exactly one decoded_state pulse; overrun=0.
REQ-027 Busy request.
- Stimulus: second edge with a different ciphertext 100 cycles into DECODE.
- With QUEUE_EN: second plaintext appears 318 cycles after the first HOLD ends; overrun=0.
- Without QUEUE_EN: no second pulse; overrun=1.
REQ-028 QUEUE_EN, three edges in one DECODE -> two decoded_state pulses, overrun=1.
REQ-029 Reset mid-decode.
- Stimulus: rst_n=0 for one cycle at DECODE count 200.
- Response: all outputs zero and no pulse.
- Follow-up: a new edge then decodes correctly with full 318-cycle latency.
REQ-030 Data isolation: encoded_data changed every cycle after the capture edge -> the captured ciphertext is decoded.
